pixel_fifo_writer: RTL and testbench
====================================

// Module: pixel_fifo_writer
// PURPOSE
//  Producer side of the VGA pixel FIFO. On each frame-start pulse, generates one full frame
//  (H_RES x V_RES) of 24-bit RGB pixels in raster order (left->right, top->bottom), and writes them
//  into the pixel FIFO whose read side is drained by the VGA controller. Frame content is a solid
//  background plus one axis-aligned rectangular sprite; it is the first-stage game renderer.
// PARAMETERS
//  H_RES     640  active pixels per line
//  V_RES     480  active lines per frame
//  SPRITE_W  32   sprite width in pixels
//  SPRITE_H  32   sprite height in lines
// PORTS
//  clk25        in   1   pixel clock, 25 MHz (same domain as FIFO write side)
//  rstN         in   1   reset, asynchronous, active-low
//  frameStart   in   1   1-cycle pulse; request to render the next frame
//  enable       in   1   renderer enable, sampled only on frameStart
//  bgColor      in   24  background RGB {R,G,B}
//  spriteColor  in   24  sprite RGB {R,G,B}
//  spriteX      in   10  sprite left column (0..1023)
//  spriteY      in   10  sprite top line (0..1023)
//  clearErr     in   1   clears lateFrame
//  fifo_full    in   1   FIFO cannot accept a word this cycle
//  fifo_wr_en   out  1   write strobe; word accepted on the edge where fifo_wr_en=1
//  fifo_data    out  32  {8'h00, R[7:0], G[7:0], B[7:0]}
//  busy         out  1   1 while in FILL
//  frameDone    out  1   1-cycle pulse after the last pixel of a frame is written
//  lateFrame    out  1   sticky: frameStart arrived while FILL was in progress
// BEHAVIOUR
//  Reset (async, rstN=0): state=IDLE, x=0, y=0, latched colours/positions=0, busy=0, frameDone=0,
//   lateFrame=0, fifo_wr_en=0, fifo_data=0. Reset mid-frame aborts immediately; no further writes.
//  States: IDLE, FILL.
//   IDLE: fifo_wr_en=0, fifo_data=0. If frameStart&&enable: latch bgColor, spriteColor, spriteX,
//    spriteY; x<=0, y<=0; go to FILL. If frameStart&&!enable: stay in IDLE, no writes.
//   FILL: fifo_wr_en = !fifo_full (combinational from state and fifo_full; no write while full).
//    fifo_data is combinational from registered x, y and latched parameters; it is stable while stalled.
//    On each edge with fifo_wr_en=1: if x==H_RES-1, x<=0 and y<=y+1, else x<=x+1.
//    A write at (H_RES-1, V_RES-1) is the last write: go to IDLE; frameDone=1 the following cycle only.
//    frameStart while in FILL (any enable): lateFrame<=1; relatch inputs; x<=0, y<=0; stay in FILL
//    (restart the frame). This takes priority over the stall and the advance in the same cycle.
//    frameStart coinciding with the last write: treat as restart (lateFrame=1, no frameDone).
//  Pixel colour: sprite hit = (x>=sX) && (x<sX+SPRITE_W) && (y>=sY) && (y<sY+SPRITE_H).
//   The compare uses 11-bit sums (no wrap), so sprites overlapping the right or bottom edge are
//   clipped and never reappear at the left or top. Sprite colour if hit, otherwise background.
//  Throughput: 1 pixel/cycle when not full. Latency: the first write can occur in the cycle after
//   frameStart. enable is ignored during FILL (frame always completes).
//  lateFrame: set as above; cleared by clearErr when no set event occurs in that cycle (set wins).
//  Counters: x is 10 bits and y is 10 bits; neither exceeds H_RES-1 or V_RES-1 respectively.
// CONFIGURATION
//  CHECKERBOARD_BG_EN defined: the background is a 32x32 checkerboard. It uses the latched bgColor
//   where (x[5]^y[5])==0, and ~bgColor (bitwise) elsewhere. Sprite rules are unchanged.
//  Not defined: the background is solid latched bgColor. There are no other differences.
// TESTING
//  1 bg=112233, spr=FF0000 @(0,0), full=0, frameStart -> word0=00FF0000, word31=00FF0000,
//    word32=00112233; 307200 writes; frameDone 1 cycle after the last write; busy low afterwards.
//  2 hold fifo_full for 10 cycles at pixel 700 -> fifo_wr_en=0 for those cycles, fifo_data held;
//    the resumed stream is gap-free (pixel 700 is the next written); the total is still 307200.
//  3 spr @(620,470) -> pixel (639,479)=sprite colour and is the last word; pixels (0..11,0)=bg (no wrap).
//  4 frameStart again after 1000 writes -> lateFrame=1; next word is pixel (0,0); no frameDone;
//    clearErr pulse -> lateFrame=0.
//  5 enable=0 at frameStart -> no writes, busy=0; enable=1 then dropped mid-frame -> frame completes.
//  6 change spriteX/bgColor mid-frame -> no effect until the next frameStart. With CHECKERBOARD_BG_EN,
//    bg=000000 -> pixel (32,0)=00FFFFFF and pixel (32,32)=00000000.

Source files
------------

// File: rtl/pixel_fifo_writer_if.sv
// Write-side bus of the VGA pixel FIFO.
//   fifo_full  : FIFO cannot accept a word this cycle (driven by the FIFO)
//   fifo_wr_en : write strobe; a word is accepted on the clock edge where it is 1
//   fifo_data  : {8'h00, R, G, B} word presented with fifo_wr_en
// master = producer (pixel_fifo_writer), slave = FIFO write port.
interface pixel_fifo_writer_if;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_data;

  modport master (
    input  fifo_full,
    output fifo_wr_en,
    output fifo_data
  );

  modport slave (
    output fifo_full,
    input  fifo_wr_en,
    input  fifo_data
  );
endinterface

// File: rtl/pixel_fifo_writer.sv
// pixel_fifo_writer: producer side of the VGA pixel FIFO.
// On a frameStart pulse (with enable high) it latches the colours and sprite
// position and streams one H_RES x V_RES frame of pixels in raster order into
// the FIFO. Each pixel is the solid background, or the sprite colour inside the
// SPRITE_W x SPRITE_H rectangle whose top-left corner is (spriteX, spriteY).
// Sprites that run past the right/bottom edge are clipped, never wrapped.
//
// Build option: define CHECKERBOARD_BG_EN to turn the background into a 32x32
// checkerboard alternating between bgColor and ~bgColor.
//
// Ports:
//   clk25        pixel clock (FIFO write-side domain)
//   rstN         asynchronous active-low reset; aborts a frame immediately
//   frameStart   1-cycle render request
//   enable       renderer enable, only looked at on frameStart
//   bgColor      background {R,G,B}
//   spriteColor  sprite {R,G,B}
//   spriteX/Y    sprite top-left column / line
//   clearErr     clears lateFrame
//   fifo         FIFO write bus (fifo_full in; fifo_wr_en, fifo_data out)
//   busy         high while a frame is being written
//   frameDone    1-cycle pulse after the last pixel of a frame is written
//   lateFrame    sticky: frameStart arrived while a frame was in progress
module pixel_fifo_writer #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32
) (
  input  logic                       clk25,
  input  logic                       rstN,
  input  logic                       frameStart,
  input  logic                       enable,
  input  logic [23:0]                bgColor,
  input  logic [23:0]                spriteColor,
  input  logic [9:0]                 spriteX,
  input  logic [9:0]                 spriteY,
  input  logic                       clearErr,
  pixel_fifo_writer_if.master        fifo,
  output logic                       busy,
  output logic                       frameDone,
  output logic                       lateFrame
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [9:0]  X_LAST = 10'(H_RES - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_RES - 1);
  localparam logic [10:0] SPR_W  = 11'(SPRITE_W);
  localparam logic [10:0] SPR_H  = 11'(SPRITE_H);

  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [23:0] bg_q, bg_d;
  logic [23:0] spr_q, spr_d;
  logic [9:0]  sx_q, sx_d;
  logic [9:0]  sy_q, sy_d;
  logic        frame_done_q, frame_done_d;
  logic        late_q, late_d;

  logic        wr_en;
  logic        last_pix;
  logic        hit;
  logic [23:0] bg_pix;
  logic [23:0] pix;

  always_ff @(posedge clk25 or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      bg_q         <= '0;
      spr_q        <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      frame_done_q <= 1'b0;
      late_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bg_q         <= bg_d;
      spr_q        <= spr_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      frame_done_q <= frame_done_d;
      late_q       <= late_d;
    end
  end

  // A write happens on every FILL cycle the FIFO has room, including the
  // cycle of a restart: the word on the bus is still the current pixel.
  assign wr_en    = (state_q == FILL) && !fifo.fifo_full;
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    bg_d         = bg_q;
    spr_d        = spr_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    frame_done_d = 1'b0;
    late_d       = clearErr ? 1'b0 : late_q;

    unique case (state_q)
      IDLE: begin
        if (frameStart && enable) begin
          bg_d    = bgColor;
          spr_d   = spriteColor;
          sx_d    = spriteX;
          sy_d    = spriteY;
          x_d     = '0;
          y_d     = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (frameStart) begin
          // Restart wins over stall, advance and end-of-frame.
          late_d = 1'b1;
          bg_d   = bgColor;
          spr_d  = spriteColor;
          sx_d   = spriteX;
          sy_d   = spriteY;
          x_d    = '0;
          y_d    = '0;
        end else if (wr_en) begin
          if (last_pix) begin
            x_d          = '0;
            y_d          = '0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 10'd1;
          end else begin
            x_d = x_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // 11-bit compares so a sprite near column/line 1023 cannot wrap back to 0.
  assign hit = ({1'b0, x_q} >= {1'b0, sx_q}) && ({1'b0, x_q} < ({1'b0, sx_q} + SPR_W)) &&
               ({1'b0, y_q} >= {1'b0, sy_q}) && ({1'b0, y_q} < ({1'b0, sy_q} + SPR_H));

`ifdef CHECKERBOARD_BG_EN
  assign bg_pix = (x_q[5] ^ y_q[5]) ? ~bg_q : bg_q;
`else
  assign bg_pix = bg_q;
`endif

  assign pix = hit ? spr_q : bg_pix;

  assign fifo.fifo_wr_en = wr_en;
  assign fifo.fifo_data  = (state_q == FILL) ? {8'h00, pix} : 32'h0000_0000;
  assign busy            = (state_q == FILL);
  assign frameDone       = frame_done_q;
  assign lateFrame       = late_q;

endmodule

// File: tb/tb_pixel_fifo_writer.sv
// Testbench for pixel_fifo_writer on a reduced 64x48 frame. Frame starts push
// the expected word stream into a scoreboard queue; a negedge monitor pops and
// compares on every FIFO write, and also tracks frameDone and stall behaviour.
module tb_pixel_fifo_writer;
  localparam int H  = 64;
  localparam int V  = 48;
  localparam int SW = 32;
  localparam int SH = 32;

  typedef struct {
    logic [31:0] data;
    bit          last;
  } exp_t;

  logic        clk25 = 1'b0;
  logic        rstN;
  logic        frameStart, enable, clearErr;
  logic [23:0] bgColor, spriteColor;
  logic [9:0]  spriteX, spriteY;
  logic        busy, frameDone, lateFrame;

  pixel_fifo_writer_if pf ();

  pixel_fifo_writer #(.H_RES(H), .V_RES(V), .SPRITE_W(SW), .SPRITE_H(SH)) dut (
    .clk25(clk25), .rstN(rstN), .frameStart(frameStart), .enable(enable),
    .bgColor(bgColor), .spriteColor(spriteColor), .spriteX(spriteX), .spriteY(spriteY),
    .clearErr(clearErr), .fifo(pf), .busy(busy), .frameDone(frameDone), .lateFrame(lateFrame)
  );

  always #20 clk25 = ~clk25;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   frame_writes = 0;
  bit   done_pend = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference pixel straight from the frame description.
  function automatic logic [31:0] ref_pixel(int x, int y, logic [23:0] bg, logic [23:0] spr,
                                            int sx, int sy);
    logic [23:0] c;
    c = bg;
`ifdef CHECKERBOARD_BG_EN
    if (((x / 32) + (y / 32)) % 2 == 1) c = ~bg;
`endif
    if (x >= sx && x < sx + SW && y >= sy && y < sy + SH) c = spr;
    return {8'h00, c};
  endfunction

  function automatic void push_frame(logic [23:0] bg, logic [23:0] spr, int sx, int sy);
    exp_t e;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        e.data = ref_pixel(x, y, bg, spr, sx, sy);
        e.last = (x == H - 1) && (y == V - 1);
        q.push_back(e);
      end
    frame_writes = 0;
  endfunction

  // Monitor: sampled on the falling edge, i.e. the values the next rising edge will see.
  always @(negedge clk25) begin
    exp_t e;
    if (rstN) begin
      check("frameDone", {31'd0, frameDone}, {31'd0, done_pend});
      done_pend = 1'b0;
      if (pf.fifo_full && busy) begin
        check("stall_wr_en", {31'd0, pf.fifo_wr_en}, 32'd0);
        if (q.size() > 0) check("stall_data", pf.fifo_data, q[0].data);
      end
      if (pf.fifo_wr_en) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got %h expected no write", pf.fifo_data);
        end else begin
          e = q.pop_front();
          check($sformatf("word%0d", frame_writes), pf.fifo_data, e.data);
          frame_writes++;
          if (e.last) done_pend = 1'b1;
        end
      end
    end
  end

  task automatic randomize_inputs();
    bgColor     = 24'($urandom);
    spriteColor = 24'($urandom);
    spriteX     = 10'($urandom);
    spriteY     = 10'($urandom);
    enable      = 1'($urandom);
  endtask

  // Issue a frameStart; the queue is rebuilt just after the monitor has
  // consumed the word written on the frameStart edge.
  task automatic start_frame(logic [23:0] bg, logic [23:0] spr, int sx, int sy, logic en);
    @(posedge clk25); #1;
    bgColor = bg; spriteColor = spr; spriteX = 10'(sx); spriteY = 10'(sy);
    enable = en; frameStart = 1'b1;
    @(negedge clk25); #1;
    if (en || busy) begin
      q.delete();
      push_frame(bg, spr, sx, sy);
    end
    @(posedge clk25); #1;
    frameStart = 1'b0;
  endtask

  // mode 0: no backpressure, 1: 10-cycle stall at pixel 700, 2: random stalls.
  // stop_at > 0 returns once that many words of the frame were written.
  task automatic run_frame(int mode, int stop_at, bit scramble);
    int cycles = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    while (q.size() > 0 && cycles < 20000 && !(stop_at > 0 && frame_writes >= stop_at)) begin
      @(posedge clk25); #1;
      cycles++;
      if (scramble) randomize_inputs();
      if (mode == 1 && !stalled && frame_writes == 700) begin
        stalled = 1'b1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        pf.fifo_full = 1'b1;
        stall_left--;
      end else if (mode == 2) begin
        pf.fifo_full = ($urandom_range(0, 3) == 0);
      end else begin
        pf.fifo_full = 1'b0;
      end
    end
    if (cycles >= 20000) check("frame_timeout", 32'(q.size()), 32'd0);
    @(posedge clk25); #1;
    pf.fifo_full = 1'b0;
    if (stop_at == 0) begin
      @(posedge clk25); #1;
      @(posedge clk25); #1;
      check("frame_writes", 32'(frame_writes), 32'(H * V));
      check("busy_after", {31'd0, busy}, 32'd0);
      check("data_idle", pf.fifo_data, 32'd0);
    end
  endtask

  initial begin
    rstN = 1'b0; frameStart = 1'b0; enable = 1'b0; clearErr = 1'b0;
    bgColor = '0; spriteColor = '0; spriteX = '0; spriteY = '0;
    pf.fifo_full = 1'b0;
    #5;
    check("rst_wr_en", {31'd0, pf.fifo_wr_en}, 32'd0);
    check("rst_data", pf.fifo_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frameDone", {31'd0, frameDone}, 32'd0);
    check("rst_lateFrame", {31'd0, lateFrame}, 32'd0);
    repeat (3) @(posedge clk25);
    #1 rstN = 1'b1;

    // Sprite at origin, fixed stall at pixel 700.
    start_frame(24'h112233, 24'hFF0000, 0, 0, 1'b1);
    check("busy_fill", {31'd0, busy}, 32'd1);
    run_frame(1, 0, 1'b0);

    // Sprite clipped at the bottom-right corner; inputs scrambled mid-frame.
    start_frame(24'h00A5C3, 24'h00FF00, H - 20, V - 10, 1'b1);
    run_frame(0, 0, 1'b1);

    // Sprite far off-screen near the 10-bit limit.
    start_frame(24'h405060, 24'hFFFFFF, 1010, 1015, 1'b1);
    run_frame(2, 0, 1'b0);

    // enable low at frameStart: nothing happens.
    start_frame(24'h123456, 24'h654321, 5, 5, 1'b0);
    repeat (20) @(posedge clk25);
    #1;
    check("disabled_busy", {31'd0, busy}, 32'd0);
    check("disabled_queue", 32'(q.size()), 32'd0);

    // Restart after 1000 writes.
    start_frame(24'h0F0F0F, 24'hF0F0F0, 10, 3, 1'b1);
    run_frame(0, 1000, 1'b1);
    check("late_before", {31'd0, lateFrame}, 32'd0);
    start_frame(24'h2468AC, 24'h13579B, 40, 20, 1'($urandom));
    check("late_set", {31'd0, lateFrame}, 32'd1);
    @(posedge clk25); #1 clearErr = 1'b1;
    @(posedge clk25); #1 clearErr = 1'b0;
    check("late_cleared", {31'd0, lateFrame}, 32'd0);
    run_frame(2, 0, 1'b1);

    // Black background (checkerboard inverts to white in the odd squares).
    start_frame(24'h000000, 24'hABCDEF, 200, 200, 1'b1);
    run_frame(0, 0, 1'b0);

    // Fully random frames.
    for (int f = 0; f < 3; f++) begin
      start_frame(24'($urandom), 24'($urandom), $urandom_range(0, 80), $urandom_range(0, 60), 1'b1);
      run_frame(2, 0, 1'b1);
    end

    // Reset mid-frame aborts the stream.
    start_frame(24'h777777, 24'h888888, 0, 0, 1'b1);
    run_frame(0, 500, 1'b0);
    @(posedge clk25); #1;
    rstN = 1'b0;
    q.delete();
    done_pend = 1'b0;
    #2;
    check("midrst_wr_en", {31'd0, pf.fifo_wr_en}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_data", pf.fifo_data, 32'd0);
    repeat (2) @(posedge clk25);
    #1 rstN = 1'b1;
    repeat (10) @(posedge clk25);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
